// File: rtl/axis_pkg.sv
// axis_pkg: shared beat layout, default sizes and keep-popcount helper for the stream sink
package axis_pkg;
  localparam int N = 4;
  localparam int DEPTH_DEF = 8;
  typedef struct packed {
    logic [8*N-1:0] data;
    logic [N-1:0]   keep;
    logic           last;
    logic           dest;
    logic           user;
  } axis_beat_t;
  function automatic logic [7:0] popcount_keep(input logic [63:0] k);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + {7'd0, k[i]};
    return c;
  endfunction
endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: first-word-fall-through FIFO with count-based empty/full and zeroed head when empty
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter type T = axis_beat_t,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  T            din,
  input  logic        pop,
  output T            dout,
  output logic        empty,
  output logic [AW:0] count
);
  T mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign do_push = push && count != (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign dout = empty ? T'('0) : mem[rptr];
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/slave_axi_stream.sv
// slave_axi_stream: AXI4-Stream sink with sanitising FWFT buffer, packet byte counter and TID check
module slave_axi_stream
  import axis_pkg::*;
#(
  parameter int n = N,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             tvalid,
  output logic             tready,
  input  logic [8*n-1:0]   tdata,
  input  logic [n-1:0]     tstrb,
  input  logic [n-1:0]     tkeep,
  input  logic             tlast,
  input  logic             TID,
  input  logic             TDEST,
  input  logic             TUSER,
  input  logic             rd_en,
  output logic [8*n-1:0]   rd_data,
  output logic [n-1:0]     rd_keep,
  output logic             rd_last,
  output logic             rd_dest,
  output logic             rd_user,
  output logic             rd_empty,
  output logic             pkt_active,
  output logic             pkt_done,
  output logic [CNT_W-1:0] pkt_bytes,
  output logic             id_err
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [8*n-1:0] data;
    logic [n-1:0]   keep;
    logic           last;
    logic           dest;
    logic           user;
  } beat_t;
  typedef enum logic {IDLE, PKT} state_t;
  state_t state;
  beat_t din, dout;
  logic rst_q, tid_q, acc, push, pop;
  logic [AW:0] count, count_nx;
  logic [n-1:0] mask_b;
  logic [8*n-1:0] mask;
  logic [CNT_W-1:0] cnt, sum;
  logic [CNT_W:0] raw;
  assign acc = tvalid && tready;
  assign push = acc && (|tkeep || tlast);
  assign pop = rd_en && !rd_empty;
  assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
  assign mask_b = tkeep & tstrb;
  for (genvar i = 0; i < n; i++) begin : g_mask
    assign mask[8*i +: 8] = {8{mask_b[i]}};
  end
  assign din = '{data: tdata & mask, keep: tkeep, last: tlast, dest: TDEST, user: TUSER};
  assign raw = {1'b0, cnt} + (CNT_W+1)'(popcount_keep(64'(tkeep)));
  assign sum = raw[CNT_W] ? '1 : raw[CNT_W-1:0];
  assign {rd_data, rd_keep, rd_last, rd_dest, rd_user} = dout;
  assign pkt_active = state == PKT;
  axis_sync_fifo #(.T(beat_t), .DEPTH(DEPTH)) u_fifo (
    .clk(aclk),
    .rst(areset),
    .push(push),
    .din(din),
    .pop(rd_en),
    .dout(dout),
    .empty(rd_empty),
    .count(count)
  );
  // rst_q holds tready low for one extra edge after reset release
  always_ff @(posedge aclk)
    if (areset) begin
      rst_q <= 1'b1;
      tready <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      tid_q <= 1'b0;
      pkt_done <= 1'b0;
      pkt_bytes <= '0;
      id_err <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      tready <= !rst_q && count_nx < (AW+1)'(DEPTH);
      pkt_done <= acc && tlast;
      id_err <= acc && state == PKT && TID != tid_q;
      if (acc) begin
        state <= tlast ? IDLE : PKT;
        cnt <= tlast ? '0 : sum;
        if (tlast) pkt_bytes <= sum;
        if (state == IDLE) tid_q <= TID;
      end
    end
endmodule

// File: tb/tb_slave_axi_stream.sv
// tb_slave_axi_stream: table-driven and directed checks of the stream sink
module tb_slave_axi_stream;
  localparam logic H = 1'b1, L = 1'b0;
  logic aclk = 1'b0, areset = 1'b1, tvalid = 1'b0, tlast = 1'b0, tid = 1'b0, tdest = 1'b0, tuser = 1'b0, rd_en = 1'b0;
  logic [31:0] tdata = '0;
  logic [3:0] tstrb = '0, tkeep = '0;
  logic tready, rd_last, rd_dest, rd_user, rd_empty, pkt_active, pkt_done, id_err;
  logic [31:0] rd_data;
  logic [3:0] rd_keep;
  logic [15:0] pkt_bytes;
  int n_pass = 0, n_tot = 0;
  typedef struct {
    logic tvalid;
    logic [31:0] tdata;
    logic [3:0] tstrb;
    logic [3:0] tkeep;
    logic tlast, tid, dest, user, rd_en;
    logic [31:0] x_data;
    logic [3:0] x_keep;
    logic x_last, x_dest, x_user, x_empty, x_active, x_done;
    logic [15:0] x_bytes;
    logic x_iderr, x_tready;
  } vec_t;
  vec_t v [14];
  slave_axi_stream dut (
    .aclk(aclk), .areset(areset), .tvalid(tvalid), .tready(tready), .tdata(tdata),
    .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .TID(tid), .TDEST(tdest), .TUSER(tuser),
    .rd_en(rd_en), .rd_data(rd_data), .rd_keep(rd_keep), .rd_last(rd_last), .rd_dest(rd_dest),
    .rd_user(rd_user), .rd_empty(rd_empty), .pkt_active(pkt_active), .pkt_done(pkt_done),
    .pkt_bytes(pkt_bytes), .id_err(id_err)
  );
  always #5 aclk = ~aclk;
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic chk_row(input int i, input vec_t e);
    string s;
    s = $sformatf("row%0d", i);
    chk({s, " rd_data"}, rd_data, e.x_data);
    chk({s, " rd_keep"}, 32'(rd_keep), 32'(e.x_keep));
    chk({s, " rd_last"}, 32'(rd_last), 32'(e.x_last));
    chk({s, " rd_dest"}, 32'(rd_dest), 32'(e.x_dest));
    chk({s, " rd_user"}, 32'(rd_user), 32'(e.x_user));
    chk({s, " rd_empty"}, 32'(rd_empty), 32'(e.x_empty));
    chk({s, " pkt_active"}, 32'(pkt_active), 32'(e.x_active));
    chk({s, " pkt_done"}, 32'(pkt_done), 32'(e.x_done));
    chk({s, " pkt_bytes"}, 32'(pkt_bytes), 32'(e.x_bytes));
    chk({s, " id_err"}, 32'(id_err), 32'(e.x_iderr));
    chk({s, " tready"}, 32'(tready), 32'(e.x_tready));
  endtask
  initial begin
    int acc;
    logic will;
    v[0]  = '{H, 32'h1, 4'hF, 4'hF, L, L, L, L, H, 32'h1, 4'hF, L, L, L, L, H, L, 16'd0, L, H};
    v[1]  = '{H, 32'h2, 4'hF, 4'hF, L, L, L, L, H, 32'h2, 4'hF, L, L, L, L, H, L, 16'd0, L, H};
    v[2]  = '{H, 32'h3, 4'hF, 4'hF, L, L, L, L, H, 32'h3, 4'hF, L, L, L, L, H, L, 16'd0, L, H};
    v[3]  = '{H, 32'h4, 4'hF, 4'hF, H, L, L, L, H, 32'h4, 4'hF, H, L, L, L, L, H, 16'd16, L, H};
    v[4]  = '{L, 32'h0, 4'h0, 4'h0, L, L, L, L, H, 32'h0, 4'h0, L, L, L, H, L, L, 16'd16, L, H};
    v[5]  = '{H, 32'h11223344, 4'hF, 4'hF, L, L, H, H, H, 32'h11223344, 4'hF, L, H, H, L, H, L, 16'd16, L, H};
    v[6]  = '{H, 32'hAABBCCDD, 4'h1, 4'h3, H, L, L, L, H, 32'h000000DD, 4'h3, H, L, L, L, L, H, 16'd6, L, H};
    v[7]  = '{L, 32'h0, 4'h0, 4'h0, L, L, L, L, H, 32'h0, 4'h0, L, L, L, H, L, L, 16'd6, L, H};
    v[8]  = '{H, 32'hA, 4'hF, 4'hF, L, L, L, L, H, 32'hA, 4'hF, L, L, L, L, H, L, 16'd6, L, H};
    v[9]  = '{H, 32'hDEAD, 4'hF, 4'h0, L, L, L, L, H, 32'h0, 4'h0, L, L, L, H, H, L, 16'd6, L, H};
    v[10] = '{H, 32'hFFFF1234, 4'h3, 4'hF, L, H, L, L, H, 32'h00001234, 4'hF, L, L, L, L, H, L, 16'd6, H, H};
    v[11] = '{H, 32'h55, 4'hF, 4'h0, H, L, L, L, H, 32'h0, 4'h0, H, L, L, L, L, H, 16'd8, L, H};
    v[12] = '{L, 32'h0, 4'h0, 4'h0, L, L, L, L, H, 32'h0, 4'h0, L, L, L, H, L, L, 16'd8, L, H};
    v[13] = '{L, 32'h0, 4'h0, 4'h0, L, L, L, L, H, 32'h0, 4'h0, L, L, L, H, L, L, 16'd8, L, H};
    // reset held for three edges, then released
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("reset tready", 32'(tready), 32'd0);
      chk("reset rd_empty", 32'(rd_empty), 32'd1);
    end
    areset = 1'b0;
    @(negedge aclk);
    chk("release edge1 tready", 32'(tready), 32'd0);
    @(negedge aclk);
    chk("release edge2 tready", 32'(tready), 32'd1);
    chk("idle rd_empty", 32'(rd_empty), 32'd1);
    chk("idle pkt_bytes", 32'(pkt_bytes), 32'd0);
    chk("idle pkt_active", 32'(pkt_active), 32'd0);
    chk("idle rd_data", rd_data, 32'd0);
    for (int i = 0; i < 14; i++) begin
      tvalid = v[i].tvalid; tdata = v[i].tdata; tstrb = v[i].tstrb; tkeep = v[i].tkeep;
      tlast = v[i].tlast; tid = v[i].tid; tdest = v[i].dest; tuser = v[i].user; rd_en = v[i].rd_en;
      @(negedge aclk);
      chk_row(i, v[i]);
    end
    // backpressure: hold tvalid, never pop, offer beats 100.. until twelve cycles pass
    rd_en = 1'b0; tvalid = 1'b1; tstrb = 4'hF; tkeep = 4'hF; tlast = 1'b0; tid = 1'b0; tdest = 1'b0; tuser = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      tdata = 32'(100 + acc);
      will = tready;
      @(negedge aclk);
      if (will) begin
        acc++;
        if (acc == 8) chk("tready after 8th accept", 32'(tready), 32'd0);
      end
    end
    chk("accepted while full", 32'(acc), 32'd8);
    chk("full head", rd_data, 32'd100);
    rd_en = 1'b1;
    @(negedge aclk);
    rd_en = 1'b0;
    chk("tready after pop", 32'(tready), 32'd1);
    @(negedge aclk);
    tvalid = 1'b0;
    chk("tready refull", 32'(tready), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain %0d data", k), rd_data, 32'(100 + k));
      chk($sformatf("drain %0d empty", k), 32'(rd_empty), 32'd0);
      rd_en = 1'b1;
      @(negedge aclk);
    end
    rd_en = 1'b0;
    chk("drained empty", 32'(rd_empty), 32'd1);
    // two beats of a packet, then reset drops it
    tvalid = 1'b1; tdata = 32'h21; tlast = 1'b0;
    @(negedge aclk);
    tdata = 32'h22;
    @(negedge aclk);
    chk("pre-reset active", 32'(pkt_active), 32'd1);
    tvalid = 1'b0; areset = 1'b1;
    @(negedge aclk);
    chk("midreset rd_empty", 32'(rd_empty), 32'd1);
    chk("midreset active", 32'(pkt_active), 32'd0);
    chk("midreset done", 32'(pkt_done), 32'd0);
    chk("midreset rd_data", rd_data, 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("post-reset done", 32'(pkt_done), 32'd0);
    chk("post-reset tready", 32'(tready), 32'd0);
    @(negedge aclk);
    chk("post-reset tready up", 32'(tready), 32'd1);
    tvalid = 1'b1; tdata = 32'h77; tlast = 1'b1;
    @(negedge aclk);
    tvalid = 1'b0; tlast = 1'b0;
    chk("one-beat done", 32'(pkt_done), 32'd1);
    chk("one-beat bytes", 32'(pkt_bytes), 32'd4);
    chk("one-beat data", rd_data, 32'h77);
    chk("one-beat active", 32'(pkt_active), 32'd0);
    @(negedge aclk);
    chk("one-beat done pulse", 32'(pkt_done), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
